// File: rtl/pipe_skid_buf.sv
// Two-entry stalling pipeline register with a registered in_ready.
// The main register drives out_data; the skid register absorbs the word accepted while the output stalls.
module pipe_skid_buf #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  // Handshake: a word moves on a port only in a cycle where valid and ready are both high at posedge.
  // The upstream valid must not depend on in_ready, and the downstream ready must not depend on out_valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_push;
  logic             w_pop;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = r_out_valid & out_ready;

  // The state encoding doubles as the occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            r_main      <= in_data;
            r_state     <= ST_ONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            r_main <= in_data;
          end else if (w_push) begin
            r_skid     <= in_data;
            r_state    <= ST_FULL;
            r_in_ready <= 1'b0;
          end else if (w_pop) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a pop can move the state.
          if (w_pop) begin
            r_main     <= r_skid;
            r_state    <= ST_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign count     = r_state;

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Directed bench for pipe_skid_buf: a scoreboard queue tracks accepted words and
// checks every word the buffer hands downstream, with direct checks on state outputs.
module tb_pipe_skid_buf;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  int checks = 0;
  int errors = 0;
  int n_pops = 0;
  int pops_before;
  logic [W-1:0] exp_q[$];

  pipe_skid_buf #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: inputs are stable at negedge, so this sees exactly what the next posedge will do.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_underflow: observed word %h expected none", out_data);
        end else begin
          chk("sb_data", out_data, exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  initial begin
    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_count", count, 2'd0);
    chk("rst_out_data", out_data, 16'h0000);
    rst_n = 1'b1;
    step();

    // Single word
    in_valid = 1'b1; in_data = 16'hA5A5; out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_data = $urandom_range(0, 16'hFFFF);
    chk("single_valid", out_valid, 1'b1);
    chk("single_data", out_data, 16'hA5A5);
    chk("single_count", count, 2'd1);
    step();
    chk("single_drain_valid", out_valid, 1'b0);
    chk("single_drain_count", count, 2'd0);

    // Streaming at full rate
    pops_before = n_pops;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1; in_data = W'(i);
      step();
      chk("stream_in_ready", in_ready, 1'b1);
      chk("stream_out_valid", out_valid, 1'b1);
      chk("stream_out_data", out_data, W'(i));
    end
    in_valid = 1'b0;
    step();
    chk("stream_end_valid", out_valid, 1'b0);
    chk("stream_pops", W'(n_pops - pops_before), W'(16));

    // Stall and fill
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h1111;
    step();
    in_data = 16'h2222;
    step();
    in_data = 16'h3333;
    chk("fill_count", count, 2'd2);
    chk("fill_in_ready", in_ready, 1'b0);
    chk("fill_data", out_data, 16'h1111);
    step();
    chk("stall_count", count, 2'd2);
    chk("stall_data", out_data, 16'h1111);
    chk("stall_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    step();
    chk("release_data", out_data, 16'h2222);
    chk("release_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("release_late_data", out_data, 16'h3333);
    step();
    chk("release_empty", count, 2'd0);

    // Flush while FULL with pop requested
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'hAAAA;
    step();
    in_data = 16'hBBBB;
    step();
    chk("pre_flush_count", count, 2'd2);
    flush = 1'b1; in_data = 16'hCCCC; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", count, 2'd0);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    step();
    chk("flush_idle_valid", out_valid, 1'b0);

    // Flush while ONE with simultaneous push and pop
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h4444;
    step();
    flush = 1'b1; in_data = 16'h5555; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1_count", count, 2'd0);
    chk("flush1_valid", out_valid, 1'b0);
    step();
    chk("flush1_idle_valid", out_valid, 1'b0);
    in_valid = 1'b1; in_data = 16'hDDDD;
    step();
    in_valid = 1'b0;
    chk("post_flush_data", out_data, 16'hDDDD);
    step();

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h6666;
    step();
    in_data = 16'h7777;
    step();
    in_valid = 1'b0;
    chk("pre_reset_count", count, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_in_ready", in_ready, 1'b1);
    chk("async_rst_count", count, 2'd0);
    chk("async_rst_data", out_data, 16'h0000);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b1; in_data = 16'h8888;
    step();
    in_valid = 1'b0;
    chk("post_reset_data", out_data, 16'h8888);
    step();
    chk("post_reset_empty", count, 2'd0);

    // Random short burst with random downstream stalls
    for (int i = 0; i < 40; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = W'($urandom_range(0, 16'hFFFF));
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk("final_empty", count, 2'd0);
    chk("final_queue", W'(exp_q.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
